// File: rtl/mips_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_pkg
// Description : Shared types for the CPU Avalon bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bus_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

endpackage
`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_arbiter
// Description : Round-robin share of one Avalon master between the fetch and
//               data ports, with a waitrequest watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_address,
  output logic        i_ack,
  output logic [31:0] i_readdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic [31:0] d_readdata,
  output logic        err,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata
);

  localparam int               C_CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = {C_CNT_W{1'b1}};
  localparam logic [C_CNT_W-1:0] C_TIMEOUT = C_CNT_W'(TIMEOUT_CYCLES);
  localparam bit               C_WDOG_EN = (TIMEOUT_CYCLES != 0);

  bus_state_t         r_state;
  bus_state_t         w_state_nxt;
  requester_t         r_owner;
  requester_t         r_last_grant;
  requester_t         w_grant;
  logic [C_CNT_W-1:0] r_wait_cnt;
  logic               w_any_req;
  logic               w_timeout;

  always_comb begin
    w_state_nxt = r_state;
    w_any_req   = i_req | d_req;
    w_timeout   = C_WDOG_EN && (r_wait_cnt == C_TIMEOUT);
    w_grant     = REQ_I;
    if (i_req && d_req) begin
      w_grant = (r_last_grant == REQ_D) ? REQ_I : REQ_D;
    end else if (d_req) begin
      w_grant = REQ_D;
    end
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = BUS;
      BUS:     if (!m_waitrequest || w_timeout) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_owner      <= REQ_I;
      r_last_grant <= REQ_D;
      r_wait_cnt   <= '0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      err          <= 1'b0;
      i_readdata   <= '0;
      d_readdata   <= '0;
      m_address    <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      m_byteenable <= '0;
    end else begin
      r_state <= w_state_nxt;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant;
            if (w_grant == REQ_D) begin
              m_address    <= d_address;
              m_read       <= ~d_write;
              m_write      <= d_write;
              m_writedata  <= d_writedata;
              m_byteenable <= d_byteenable;
            end else begin
              m_address    <= i_address;
              m_read       <= 1'b1;
              m_write      <= 1'b0;
              m_writedata  <= '0;
              m_byteenable <= 4'hF;
            end
          end
        end
        BUS: begin
          if (!m_waitrequest) begin
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            r_last_grant <= r_owner;
            if (r_owner == REQ_I) begin
              i_ack      <= 1'b1;
              i_readdata <= m_readdata;
            end else begin
              d_ack <= 1'b1;
              if (!m_write) d_readdata <= m_readdata;
            end
          end else if (w_timeout) begin
            // Abort keeps the readdata registers and the round-robin pointer.
            m_read  <= 1'b0;
            m_write <= 1'b0;
            err     <= 1'b1;
            i_ack   <= (r_owner == REQ_I);
            d_ack   <= (r_owner == REQ_D);
          end else if (r_wait_cnt != C_CNT_MAX) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        RESP: r_wait_cnt <= '0;
        default: r_wait_cnt <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_bus_arbiter
// Description : Directed and randomized checks of mips_bus_arbiter against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_bus_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_address;
  logic        i_ack;
  logic [31:0] i_readdata;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        d_ack;
  logic [31:0] d_readdata;
  logic        err;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;

  int          total = 0;
  int          bad = 0;
  bit          mdl_last_d;
  logic [31:0] mdl_ird;
  logic [31:0] mdl_drd;
  logic [69:0] bus_vec;

  assign bus_vec = {m_read, m_write, m_address, m_writedata, m_byteenable};

  mips_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_address(i_address), .i_ack(i_ack), .i_readdata(i_readdata),
    .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_ack(d_ack), .d_readdata(d_readdata), .err(err),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  // Bus image the granted requester should produce while its transaction is active.
  function automatic logic [69:0] exp_bus(input bit g_d);
    if (g_d) return {~d_write, d_write, d_address, d_writedata, d_byteenable};
    return {1'b1, 1'b0, i_address, 32'd0, 4'hF};
  endfunction

  task automatic test_reset();
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0; d_byteenable = '0;
    m_waitrequest = 1'b0; m_readdata = '0;
    repeat (2) @(negedge clk);
    total++; if ({i_ack, d_ack, err, m_read, m_write} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl got=%b exp=00000", {i_ack, d_ack, err, m_read, m_write});
    end
    total++; if ({m_address, m_writedata, m_byteenable} !== 68'd0) begin
      bad++; $display("FAIL reset_bus got=%h exp=0", {m_address, m_writedata, m_byteenable});
    end
    total++; if ({i_readdata, d_readdata} !== 64'd0) begin
      bad++; $display("FAIL reset_rd got=%h exp=0", {i_readdata, d_readdata});
    end
    mdl_last_d = 1'b1; mdl_ird = '0; mdl_drd = '0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch_only();
    i_address = 32'hBFC00000; m_readdata = 32'h24020005; m_waitrequest = 1'b0; i_req = 1'b1;
    @(negedge clk);
    total++; if ({m_read, m_write, m_byteenable, m_address} !== {1'b1, 1'b0, 4'hF, 32'hBFC00000}) begin
      bad++; $display("FAIL fetch_bus got=%h exp=%h", {m_read, m_write, m_byteenable, m_address},
                      {1'b1, 1'b0, 4'hF, 32'hBFC00000});
    end
    total++; if (i_ack !== 1'b0) begin bad++; $display("FAIL fetch_early_ack got=%b exp=0", i_ack); end
    @(negedge clk);
    total++; if (m_read !== 1'b0) begin bad++; $display("FAIL fetch_read_len got=%b exp=0", m_read); end
    total++; if ({i_ack, d_ack, err} !== 3'b100) begin
      bad++; $display("FAIL fetch_ack got=%b exp=100", {i_ack, d_ack, err});
    end
    total++; if (i_readdata !== 32'h24020005) begin
      bad++; $display("FAIL fetch_data got=%h exp=24020005", i_readdata);
    end
    i_req = 1'b0;
    @(negedge clk);
    total++; if (i_ack !== 1'b0) begin bad++; $display("FAIL fetch_ack_pulse got=%b exp=0", i_ack); end
    mdl_last_d = 1'b0; mdl_ird = 32'h24020005;
  endtask

  task automatic test_tie();
    bit g_d;
    logic [69:0] eb;
    logic [31:0] rd;
    rst = 1'b0;
    @(negedge clk);
    i_address = 32'h00400020; i_req = 1'b1;
    d_req = 1'b1; d_write = 1'b1; d_address = 32'h00001000; d_writedata = 32'hDEADBEEF;
    d_byteenable = 4'b0011; m_waitrequest = 1'b0;
    mdl_last_d = 1'b1; mdl_ird = '0; mdl_drd = '0;
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      g_d = !mdl_last_d;
      eb = exp_bus(g_d);
      @(negedge clk);
      total++; if (bus_vec !== eb) begin
        bad++; $display("FAIL tie_bus n=%0d got=%h exp=%h", n, bus_vec, eb);
      end
      rd = $urandom;
      m_readdata = rd;
      @(negedge clk);
      total++; if ({i_ack, d_ack, err} !== {!g_d, g_d, 1'b0}) begin
        bad++; $display("FAIL tie_ack n=%0d got=%b exp=%b", n, {i_ack, d_ack, err}, {!g_d, g_d, 1'b0});
      end
      mdl_last_d = g_d;
      if (!g_d) mdl_ird = rd;
      total++; if ({i_readdata, d_readdata} !== {mdl_ird, mdl_drd}) begin
        bad++; $display("FAIL tie_rd n=%0d got=%h exp=%h", n, {i_readdata, d_readdata}, {mdl_ird, mdl_drd});
      end
      @(negedge clk);
      if (n == 2) begin i_req = 1'b0; d_req = 1'b0; end
      total++; if ({m_read, m_write, i_ack, d_ack} !== 4'b0) begin
        bad++; $display("FAIL tie_idle n=%0d got=%b exp=0000", n, {m_read, m_write, i_ack, d_ack});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [69:0] eb;
    logic [31:0] rd;
    d_write = 1'b0; d_address = 32'h10008000; d_writedata = 32'h0; d_byteenable = 4'hF;
    m_waitrequest = 1'b1; d_req = 1'b1; rd = '0;
    eb = exp_bus(1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++; if (bus_vec !== eb || d_ack !== 1'b0) begin
        bad++; $display("FAIL stall_bus k=%0d got=%h/%b exp=%h/0", k, bus_vec, d_ack, eb);
      end
      m_waitrequest = (k <= 4);
      m_readdata = $urandom;
      if (k == 5) rd = m_readdata;
    end
    @(negedge clk);
    total++; if ({d_ack, i_ack, err, m_read} !== 4'b1000) begin
      bad++; $display("FAIL stall_ack got=%b exp=1000", {d_ack, i_ack, err, m_read});
    end
    total++; if (d_readdata !== rd) begin bad++; $display("FAIL stall_data got=%h exp=%h", d_readdata, rd); end
    mdl_drd = rd; mdl_last_d = 1'b1;
    d_req = 1'b0; m_waitrequest = 1'b0;
    @(negedge clk);
    total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL stall_ack_pulse got=%b exp=0", d_ack); end
  endtask

  task automatic test_timeout();
    logic [69:0] eb;
    d_write = 1'b0; d_address = 32'h1000FFFC; d_byteenable = 4'b1100;
    m_waitrequest = 1'b1; d_req = 1'b1;
    eb = exp_bus(1'b1);
    for (int k = 1; k <= T + 1; k++) begin
      @(negedge clk);
      total++; if (bus_vec !== eb || {d_ack, err} !== 2'b00) begin
        bad++; $display("FAIL tmo_active k=%0d got=%h/%b exp=%h/00", k, bus_vec, {d_ack, err}, eb);
      end
      m_readdata = $urandom;
    end
    @(negedge clk);
    total++; if ({m_read, m_write, d_ack, i_ack, err} !== 5'b00101) begin
      bad++; $display("FAIL tmo_abort got=%b exp=00101", {m_read, m_write, d_ack, i_ack, err});
    end
    total++; if (d_readdata !== mdl_drd) begin
      bad++; $display("FAIL tmo_rd_hold got=%h exp=%h", d_readdata, mdl_drd);
    end
    d_req = 1'b0; m_waitrequest = 1'b0;
    @(negedge clk);
    total++; if ({d_ack, err} !== 2'b00) begin bad++; $display("FAIL tmo_pulse got=%b exp=00", {d_ack, err}); end
    i_address = 32'h00400100; m_readdata = 32'h8C420004; i_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if ({i_ack, err, i_readdata} !== {2'b10, 32'h8C420004}) begin
      bad++; $display("FAIL tmo_next got=%h exp=%h", {i_ack, err, i_readdata}, {2'b10, 32'h8C420004});
    end
    mdl_ird = 32'h8C420004; mdl_last_d = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    d_write = 1'b1; d_address = 32'h00002000; d_writedata = 32'hCAFEF00D; d_byteenable = 4'hF;
    m_waitrequest = 1'b1; d_req = 1'b1;
    @(negedge clk);
    total++; if ({m_read, m_write} !== 2'b01) begin
      bad++; $display("FAIL rstmid_active got=%b exp=01", {m_read, m_write});
    end
    #2 rst = 1'b0;
    #1;
    total++; if ({m_read, m_write} !== 2'b00) begin
      bad++; $display("FAIL rstmid_async got=%b exp=00", {m_read, m_write});
    end
    i_address = 32'h00400200; i_req = 1'b1; m_waitrequest = 1'b0; m_readdata = 32'h3C1D1000;
    mdl_last_d = 1'b1; mdl_ird = '0; mdl_drd = '0;
    repeat (2) @(negedge clk);
    total++; if ({i_ack, d_ack, err} !== 3'b000) begin
      bad++; $display("FAIL rstmid_noack got=%b exp=000", {i_ack, d_ack, err});
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus_vec !== exp_bus(1'b0)) begin
      bad++; $display("FAIL rstmid_tie got=%h exp=%h", bus_vec, exp_bus(1'b0));
    end
    @(negedge clk);
    total++; if ({i_ack, d_ack, i_readdata} !== {2'b10, 32'h3C1D1000}) begin
      bad++; $display("FAIL rstmid_ack got=%h exp=%h", {i_ack, d_ack, i_readdata}, {2'b10, 32'h3C1D1000});
    end
    mdl_last_d = 1'b0; mdl_ird = 32'h3C1D1000;
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int pat, r, w, n_ack;
      bit stuck, g_d;
      logic [31:0] rd_exp;
      logic [69:0] eb;
      pat = $urandom_range(1, 3);
      r = $urandom_range(0, 9);
      stuck = (r == 9);
      w = stuck ? 0 : r % 4;
      i_address = $urandom; d_address = $urandom; d_writedata = $urandom;
      d_byteenable = 4'($urandom); d_write = 1'($urandom);
      i_req = pat[0]; d_req = pat[1]; m_waitrequest = 1'b1;
      g_d = (pat == 3) ? !mdl_last_d : (pat == 2);
      n_ack = stuck ? T + 2 : w + 2;
      eb = exp_bus(g_d);
      rd_exp = '0;
      for (int k = 1; k <= n_ack; k++) begin
        @(negedge clk);
        if (k < n_ack) begin
          total++; if (bus_vec !== eb || {i_ack, d_ack, err} !== 3'b000) begin
            bad++; $display("FAIL rnd_bus it=%0d k=%0d got=%h/%b exp=%h/000", it, k, bus_vec,
                            {i_ack, d_ack, err}, eb);
          end
          m_waitrequest = stuck ? 1'b1 : (k <= w);
          m_readdata = $urandom;
          if (!stuck && k == w + 1) rd_exp = m_readdata;
        end else begin
          total++; if ({m_read, m_write, i_ack, d_ack, err} !== {2'b00, !g_d, g_d, stuck}) begin
            bad++; $display("FAIL rnd_ack it=%0d got=%b exp=%b", it, {m_read, m_write, i_ack, d_ack, err},
                            {2'b00, !g_d, g_d, stuck});
          end
          if (!stuck) begin
            mdl_last_d = g_d;
            if (!g_d) mdl_ird = rd_exp;
            else if (!d_write) mdl_drd = rd_exp;
          end
          total++; if ({i_readdata, d_readdata} !== {mdl_ird, mdl_drd}) begin
            bad++; $display("FAIL rnd_rd it=%0d got=%h exp=%h", it, {i_readdata, d_readdata}, {mdl_ird, mdl_drd});
          end
          i_req = 1'b0; d_req = 1'b0; m_waitrequest = 1'b0;
        end
      end
      @(negedge clk);
      total++; if ({i_ack, d_ack, err} !== 3'b000) begin
        bad++; $display("FAIL rnd_pulse it=%0d got=%b exp=000", it, {i_ack, d_ack, err});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_tie();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Shares the CPU's single Avalon memory-mapped master between two requesters: the instruction-fetch port (read-only) and the data port (loads and stores). Each requester issues one transaction at a time. The block grants the bus round-robin, holds the transaction across `waitrequest`, and returns read data with a one-cycle acknowledge. A watchdog aborts transactions that stall too long. It sits between the multicycle CPU core and the top-level Avalon bus pins.

## Interface
- `TIMEOUT_CYCLES`, default 1023: maximum consecutive cycles with `m_waitrequest` high before abort; 0 disables the watchdog.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset (low = reset).
- `i_req` in 1: fetch request; held with `i_address` stable until `i_ack`.
- `i_address` in 32: fetch address.
- `i_ack` out 1: one-cycle completion pulse for fetch.
- `i_readdata` out 32: fetch data; valid when `i_ack`.
- `d_req` in 1: data request; fields held stable until `d_ack`.
- `d_write` in 1: 1 = store, 0 = load.
- `d_address` in 32, `d_writedata` in 32, `d_byteenable` in 4: data transaction fields.
- `d_ack` out 1: one-cycle completion pulse for data.
- `d_readdata` out 32: load data; valid when `d_ack` and not `d_write`.
- `err` out 1: high with the ack of an aborted transaction.
- `m_address` out 32, `m_read` out 1, `m_write` out 1, `m_writedata` out 32, `m_byteenable` out 4: Avalon master outputs, all registered.
- `m_waitrequest` in 1, `m_readdata` in 32: Avalon master inputs.

## Operation
- States: IDLE, BUS, RESP.
- **IDLE**:
  - If no request, stay in IDLE.
  - If exactly one of `i_req`/`d_req` is high, grant that requester.
  - If both are high, grant the one not recorded in `last_grant`.
  - On grant, latch the fields into the `m_*` registers and go to BUS.
  - A fetch drives `m_byteenable`=4'b1111, `m_write`=0, `m_writedata`=0.
- **BUS**:
  - Drive `m_read` = !write or `m_write` = write for the whole state; fields are constant.
  - If `m_waitrequest`=0 at the edge: capture `m_readdata` for reads, deassert `m_read`/`m_write`, update `last_grant`, go to RESP.
  - If `m_waitrequest`=1: increment the wait counter. When the counter reaches `TIMEOUT_CYCLES` (and `TIMEOUT_CYCLES`≠0), deassert the bus, set the error flag, go to RESP.
- **RESP**:
  - Pulse the granted requester's ack for one cycle; assert `err` alongside it if aborted.
  - Readdata register holds its value until the next completion of the same port.
  - Clear the error flag and wait counter; go to IDLE.
- A requester sees its ack and must drop or renew its request by the following edge. Because RESP is never re-arbitrated, a stale request cannot be double-granted.
- The ungranted requester's request is ignored until IDLE; it is never lost as long as it is held.
- Reset:
  - All `m_*`, acks, `err` and readdata registers go to 0; state goes to IDLE.
  - `last_grant` resets to D, so fetch wins the first tie.
  - A reset during BUS drops `m_read`/`m_write` immediately (asynchronous) and produces no ack.

## Timing
- Zero-wait-state transaction:
  - Request seen in IDLE at edge E0.
  - Bus active in cycle E0–E1; completes at E1.
  - Ack high in cycle E1–E2; IDLE from E2.
- Minimum 3 cycles per transaction. Each waitrequest cycle adds 1.
- Abort: bus active for `TIMEOUT_CYCLES`+1 cycles, then the ack with `err` in the next cycle.
- All outputs are registered; there is no combinational path from any input to any output.
- Wait counter width is clog2(`TIMEOUT_CYCLES`+1), minimum 1 bit, and saturates (no wrap-around).

## Structure
- Package `mips_bus_pkg`:
  - `bus_state_t` enum (IDLE=2'd0, BUS=2'd1, RESP=2'd2).
  - `requester_t` enum (REQ_I=1'b0, REQ_D=1'b1).
- No sub-module; the arbitration and watchdog fit in one always_ff plus a small always_comb next-state block.

## Test plan
- **Fetch only:** after reset, `i_req`=1 with `i_address`=32'hBFC00000, `m_waitrequest`=0, `m_readdata`=32'h24020005. Required: `m_read`=1 and `m_byteenable`=4'hF exactly one cycle; `i_ack` pulses on the 2nd cycle after the request with `i_readdata`=32'h24020005; `err`=0.
- **Tie, round-robin:** `i_req` and `d_req` (write, address 32'h00001000, data 32'hDEADBEEF, byteenable 4'b0011) both held from reset. Required: fetch granted first, store second, fetch third; `m_writedata`/`m_byteenable` match exactly on the store.
- **Waitrequest stall:** load with `m_waitrequest` high 4 cycles. Required: `m_address` and `m_read` stable for 5 cycles; `d_ack` exactly 6 cycles after the request; `d_readdata` equals `m_readdata` from the release cycle.
- **Timeout:** `TIMEOUT_CYCLES`=8, `m_waitrequest` stuck at 1. Required: the bus deasserts after 9 active cycles; `d_ack`=1 and `err`=1 in the same single cycle; the next request proceeds normally.
- **Reset mid-transaction:** assert `rst` low during BUS. Required: `m_read`/`m_write` go to 0 before the next clock edge; no ack; after release, a fetch wins the first tie.
